ifu_fetch: RTL

//   Instruction fetch unit: producer end of the instruction-word interface the decode/control unit consumes.

---
 rtl/ifu_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------------------------
// ifu_fetch: instruction fetch unit. It is the producer end of the instruction-word interface
// that decode consumes.
//
// Holds the PC and keeps at most one word request outstanding to instruction memory (the
// request is a valid/ready handshake and the response is valid-only). Each fetched word goes
// to decode as {inst, inst_pc, fetch_fault} under a valid/ready handshake. A redirect from
// branch/jump resolution replaces the PC and squashes any fetch still in flight. There is no
// prefetch, so the next request is issued only after decode has taken the current word.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   redirect_valid   taken branch/jump this cycle; target redirect_pc (bits [1:0] forced to 0)
//   imem_req_*       request channel: valid/ready, word address = current PC
//   imem_rsp_*       response channel: valid, data, access-fault flag
//   inst_valid/ready handshake to decode
//   inst, inst_pc    instruction word and its PC (inst = NOP_INST while inst_valid = 0)
//   fetch_fault      word came from an errored response, qualified by inst_valid
// ---------------------------------------------------------------------------------------------
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,

    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;   // response now in flight is stale and must be discarded
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;

    logic [31:0] redirect_tgt;
    logic        req_fire;
    logic        inst_fire;

    // Masking keeps every bit of redirect_pc in use. The low two bits are always dropped.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    // The state register is forced to StReq while rst is high. The request valid is also gated
    // so that no request is seen until the cycle after reset is released.
    assign imem_req_valid = (state_q == StReq) && !rst;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == StHold);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_fault    = fault_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign inst_fire = inst_valid && inst_ready;

    // Next-state logic. A redirect takes priority over every other event in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        unique case (state_q)
            StReq: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // If the old request was accepted anyway, its response still has to be
                    // received and thrown away. If it was not accepted, it is simply withdrawn.
                    if (req_fire) begin
                        state_d = StWait;
                        drop_d  = 1'b1;
                    end
                end else if (req_fire) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_rsp_valid) begin
                        // Response arrives in the same cycle as the redirect: it is stale.
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        state_d = StReq;
                        drop_d  = 1'b0;
                    end else begin
                        state_d   = StHold;
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        fault_d   = imem_rsp_err;
                    end
                end
            end

            StHold: begin
                if (redirect_valid) begin
                    // The held word is squashed even if decode takes it in the same cycle.
                    state_d = StReq;
                    pc_d    = redirect_tgt;
                    inst_d  = NOP_INST;
                    fault_d = 1'b0;
                end else if (inst_fire) begin
                    state_d = StReq;
                    pc_d    = pc_q + 32'd4;   // wraps modulo 2^32
                    inst_d  = NOP_INST;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = StReq;
            end
        endcase
    end

    // imem_rsp_valid outside StWait is a protocol error. No branch above looks at it there,
    // so such a response is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= NOP_INST;
            inst_pc_q <= 32'h0000_0000;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

endmodule
